// File: rtl/bullet_collision_scanner.sv
// Per-frame scan of the bullet table against the player box, applying damage/heal to HP.
// Optional invulnerability window: define BULLET_SCAN_INVULN_EN.
module bullet_collision_scanner #(
   parameter int NUM_BULLETS   = 3,
   parameter int HP_INIT       = 20,
   parameter int DAMAGE        = 4,
   parameter int HEAL          = 1,
   parameter int INVULN_FRAMES = 30
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [15:0]            player_pos,
   input  logic [15:0]            player_size,
   input  logic                   player_moving,
   output logic [2:0]             index2,
   input  logic [15:0]            position2,
   input  logic [15:0]            size2,
   input  logic [1:0]             color2,
   input  logic                   isRender2,
   output logic [NUM_BULLETS-1:0] indexCollide,
   output logic                   isComplete,
   output logic [7:0]             hp,
   output logic                   dead,
   output logic                   hit
`ifdef BULLET_SCAN_INVULN_EN
   ,
   output logic                   invuln
`endif
);

   // state | meaning
   // IDLE  | waiting for start
   // SCAN  | one bullet evaluated per cycle, index2 walks 0..NUM_BULLETS-1
   // DONE  | isComplete pulse, mask and hp valid
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [3:0] LAST     = 4'(NUM_BULLETS - 1);
   localparam logic [7:0] HP_MAX   = 8'(HP_INIT);
   localparam logic [7:0] DMG      = 8'(DAMAGE);
   localparam logic [8:0] HEAL_AMT = 9'(HEAL);

   state_t                 state;
   logic [3:0]             idx;
   logic [NUM_BULLETS-1:0] mask, mask_next;
   logic                   hit_acc, hurt, heal, keep, overlap, inv_active;
   logic [7:0]             hp_next;
   logic [8:0]             px, py, pw, ph, bx, by, bw, bh, heal_sum;

   assign index2   = idx[2:0];
   assign px       = {1'b0, player_pos[15:8]};
   assign py       = {1'b0, player_pos[7:0]};
   assign pw       = {1'b0, player_size[15:8]};
   assign ph       = {1'b0, player_size[7:0]};
   assign bx       = {1'b0, position2[15:8]};
   assign by       = {1'b0, position2[7:0]};
   assign bw       = {1'b0, size2[15:8]};
   assign bh       = {1'b0, size2[7:0]};
   assign heal_sum = {1'b0, hp} + HEAL_AMT;

   // 9-bit edges so boxes near 255 cannot wrap; empty boxes never overlap
   assign overlap = (pw != 9'd0) && (ph != 9'd0) && (bw != 9'd0) && (bh != 9'd0) &&
                    (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);

`ifdef BULLET_SCAN_INVULN_EN
   localparam logic [7:0] INV_LOAD = 8'(INVULN_FRAMES);
   logic [7:0] inv_cnt;
   logic       inv_loaded;
   assign inv_active = (inv_cnt != 8'd0);
   assign invuln     = inv_active;
`else
   assign inv_active = 1'b0;
`endif

   always_comb begin
      hurt = 1'b0;
      heal = 1'b0;
      if (isRender2 && overlap) begin
         case (color2)
            2'd0:    hurt = !inv_active;
            2'd1:    heal = 1'b1;
            2'd2:    hurt = player_moving && !inv_active;
            default: ;
         endcase
      end
      keep    = isRender2 && !hurt && !heal;
      hp_next = hp;
      if (hp != 8'd0) begin
         if (hurt)
            hp_next = (hp > DMG) ? hp - DMG : 8'd0;
         else if (heal)
            hp_next = (heal_sum > {1'b0, HP_MAX}) ? HP_MAX : heal_sum[7:0];
      end
      mask_next = mask;
      for (int i = 0; i < NUM_BULLETS; i++)
         if (idx == 4'(i)) mask_next[i] = keep;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= 4'd0;
         mask         <= '1;
         indexCollide <= '1;
         isComplete   <= 1'b0;
         hit          <= 1'b0;
         hit_acc      <= 1'b0;
         hp           <= HP_MAX;
         dead         <= 1'b0;
`ifdef BULLET_SCAN_INVULN_EN
         inv_cnt      <= 8'd0;
         inv_loaded   <= 1'b0;
`endif
      end else begin
         isComplete <= 1'b0;
         hit        <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= SCAN;
                  idx     <= 4'd0;
                  mask    <= '1;
                  hit_acc <= 1'b0;
`ifdef BULLET_SCAN_INVULN_EN
                  inv_loaded <= 1'b0;
`endif
               end
            end
            SCAN: begin
               hp      <= hp_next;
               dead    <= dead | (hp_next == 8'd0);
               mask    <= mask_next;
               hit_acc <= hit_acc | hurt;
               idx     <= idx + 4'd1;
`ifdef BULLET_SCAN_INVULN_EN
               if (hurt) begin
                  inv_cnt    <= INV_LOAD;
                  inv_loaded <= 1'b1;
               end
`endif
               if (idx == LAST) begin
                  state        <= DONE;
                  indexCollide <= mask_next;
                  isComplete   <= 1'b1;
                  hit          <= hit_acc | hurt;
`ifdef BULLET_SCAN_INVULN_EN
                  // the scan that loaded the window does not count against it
                  if (inv_active && !inv_loaded)
                     inv_cnt <= inv_cnt - 8'd1;
`endif
               end
            end
            DONE: begin
               state <= IDLE;
               idx   <= 4'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// Randomized + directed bench for bullet_collision_scanner with a per-scan behavioural model.
module tb_bullet_collision_scanner;
   localparam int NB  = 3;
   localparam int HPI = 20;
   localparam int DMG = 4;
   localparam int HL  = 1;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, player_moving = 1'b0;
   logic [15:0]   player_pos = 16'h0, player_size = 16'h0;
   logic [2:0]    index2;
   logic [15:0]   position2, size2;
   logic [1:0]    color2;
   logic          isRender2;
   logic [NB-1:0] indexCollide;
   logic          isComplete, dead, hit;
   logic [7:0]    hp;
`ifdef BULLET_SCAN_INVULN_EN
   logic          invuln;
`endif

   logic [15:0] b_pos  [8];
   logic [15:0] b_size [8];
   logic [1:0]  b_col  [8];
   logic        b_rend [8];

   int total = 0, bad = 0;
   int exp_idx = 0, exp_hp = HPI, exp_mask = (1 << NB) - 1;
   bit exp_cmp = 0, exp_hit = 0, exp_dead = 0, chk_en = 0;
   int m_hp = HPI;
   int seq_hp [NB+1];
   int e_mask;
   bit e_hit;

   always #5 clk = ~clk;

   assign position2 = b_pos[index2];
   assign size2     = b_size[index2];
   assign color2    = b_col[index2];
   assign isRender2 = b_rend[index2];

   bullet_collision_scanner #(
      .NUM_BULLETS(NB), .HP_INIT(HPI), .DAMAGE(DMG), .HEAL(HL), .INVULN_FRAMES(30)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .player_pos(player_pos), .player_size(player_size), .player_moving(player_moving),
      .index2(index2), .position2(position2), .size2(size2), .color2(color2),
      .isRender2(isRender2), .indexCollide(indexCollide), .isComplete(isComplete),
      .hp(hp), .dead(dead), .hit(hit)
`ifdef BULLET_SCAN_INVULN_EN
      , .invuln(invuln)
`endif
   );

   task automatic check(string name, int act, int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("index2",       int'(index2),       exp_idx);
         check("hp",           int'(hp),           exp_hp);
         check("dead",         int'(dead),         int'(exp_dead));
         check("isComplete",   int'(isComplete),   int'(exp_cmp));
         check("hit",          int'(hit),          int'(exp_hit));
         check("indexCollide", int'(indexCollide), exp_mask);
      end
   end

   task automatic set_b(int i, int x, int y, int w, int h, int c, bit r);
      b_pos[i]  = {8'(x), 8'(y)};
      b_size[i] = {8'(w), 8'(h)};
      b_col[i]  = 2'(c);
      b_rend[i] = r;
   endtask

   // Spec rules applied bullet by bullet to the current model HP.
   task automatic model_scan();
      int h, px, py, pw, ph, bx, by, bw, bh;
      bit ov, dmg, hl;
      h = m_hp;
      e_mask = 0;
      e_hit = 0;
      seq_hp[0] = h;
      px = int'(player_pos[15:8]);  py = int'(player_pos[7:0]);
      pw = int'(player_size[15:8]); ph = int'(player_size[7:0]);
      for (int i = 0; i < NB; i++) begin
         bx = int'(b_pos[i][15:8]);  by = int'(b_pos[i][7:0]);
         bw = int'(b_size[i][15:8]); bh = int'(b_size[i][7:0]);
         ov = (pw > 0) && (ph > 0) && (bw > 0) && (bh > 0) &&
              (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
         dmg = b_rend[i] && ov && ((b_col[i] == 2'd0) || (b_col[i] == 2'd2 && player_moving));
         hl  = b_rend[i] && ov && (b_col[i] == 2'd1);
         if (b_rend[i] && !dmg && !hl) e_mask = e_mask | (1 << i);
         if (dmg) e_hit = 1;
         if (h > 0) begin
            if (dmg)     h = (h > DMG) ? h - DMG : 0;
            else if (hl) h = (h + HL > HPI) ? HPI : h + HL;
         end
         seq_hp[i+1] = h;
      end
      m_hp = h;
   endtask

   task automatic set_reset_exp();
      exp_idx = 0; exp_hp = HPI; exp_dead = 0; exp_cmp = 0; exp_hit = 0;
      exp_mask = (1 << NB) - 1;
      m_hp = HPI;
   endtask

   task automatic do_reset();
      @(negedge clk) begin rst_n = 1'b0; start = 1'b0; end
      @(posedge clk) #1;
      set_reset_exp();
      chk_en = 1;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic run_scan(bit noisy);
      model_scan();
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0;
      exp_idx = 0;
      for (int k = 1; k <= NB; k++) begin
         @(negedge clk) start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk) #1;
         exp_idx  = k % 8;
         exp_hp   = seq_hp[k];
         exp_dead = (seq_hp[k] == 0);
         if (k == NB) begin
            exp_cmp = 1; exp_mask = e_mask; exp_hit = e_hit;
         end
      end
      @(negedge clk) start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk) #1;
      start = 1'b0;
      exp_cmp = 0; exp_hit = 0; exp_idx = 0;
   endtask

   initial begin
      int px, py;
      for (int i = 0; i < 8; i++) set_b(i, 'hC0, 'hC0, 4, 4, 0, 1'b1);
      do_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_hp", int'(hp), 20);
      check("rst_mask", int'(indexCollide), 7);
      check("rst_cmp", int'(isComplete), 0);
      check("rst_dead", int'(dead), 0);

      player_pos = 16'h2020; player_size = 16'h1010;
      set_b(0, 'h28, 'h28, 8, 8, 0, 1'b1);
      run_scan(0);
      check("white_mask", int'(indexCollide), 6);
      check("white_hp", int'(hp), 16);
      check("white_hit_model", int'(e_hit), 1);

      set_b(0, 'h28, 'h28, 8, 8, 2, 1'b1);
      player_moving = 1'b0;
      run_scan(1);
      check("blue_still_mask", int'(indexCollide), 7);
      check("blue_still_hp", int'(hp), 16);
      check("blue_still_hit_model", int'(e_hit), 0);
      player_moving = 1'b1;
      run_scan(0);
      check("blue_move_mask", int'(indexCollide), 6);
      check("blue_move_hp", int'(hp), 12);
      player_moving = 1'b0;

      set_b(0, 'h30, 'h28, 8, 8, 0, 1'b1);
      run_scan(0);
      check("edge_mask", int'(indexCollide), 7);
      check("edge_hp", int'(hp), 12);

      do_reset();
      set_b(0, 'h28, 'h28, 8, 8, 1, 1'b1);
      run_scan(0);
      check("green_full_hp", int'(hp), 20);
      check("green_full_mask", int'(indexCollide), 6);

      for (int i = 0; i < NB; i++) set_b(i, 'h24 + 2*i, 'h24, 8, 8, 0, 1'b1);
      run_scan(0);
      check("triple_hp", int'(hp), 8);
      set_b(1, 'h24, 'h24, 8, 8, 1, 1'b1);
      set_b(2, 'h26, 'h26, 8, 8, 1, 1'b1);
      run_scan(1);
      check("hp6", int'(hp), 6);
      set_b(1, 'hC0, 'hC0, 4, 4, 0, 1'b1);
      set_b(2, 'hC0, 'hC0, 4, 4, 0, 1'b1);
      run_scan(0);
      check("hp2", int'(hp), 2);
      run_scan(1);
      check("hp0", int'(hp), 0);
      check("dead", int'(dead), 1);
      set_b(0, 'h28, 'h28, 8, 8, 1, 1'b1);
      run_scan(0);
      check("dead_heal_hp", int'(hp), 0);
      check("dead_heal_mask", int'(indexCollide), 6);

      // abort at T2 with no bullets drawn: a published partial mask would be 000
      for (int i = 0; i < 8; i++) b_rend[i] = 1'b0;
      @(negedge clk) start = 1'b1;
      @(posedge clk) #1;
      start = 1'b0; exp_idx = 0;
      @(posedge clk) #1;
      exp_idx = 1;
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk) #1;
      set_reset_exp();
      @(negedge clk) rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("abort_mask", int'(indexCollide), 7);
      check("abort_hp", int'(hp), 20);

      for (int s = 0; s < 150; s++) begin
         px = $urandom_range(0, 255);
         py = $urandom_range(0, 255);
         player_pos  = {8'(px), 8'(py)};
         player_size = {8'($urandom_range(0, 31)), 8'($urandom_range(0, 31))};
         player_moving = 1'($urandom_range(0, 1));
         for (int i = 0; i < NB; i++)
            set_b(i, (px + $urandom_range(0, 48) - 16) & 255,
                     (py + $urandom_range(0, 48) - 16) & 255,
                     $urandom_range(0, 15), $urandom_range(0, 15),
                     $urandom_range(0, 3), ($urandom_range(0, 4) != 0));
         if ($urandom_range(0, 7) == 0) do_reset();
         run_scan(1'($urandom_range(0, 1)));
      end

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bullet_collision_scanner.md
Name: bullet_collision_scanner

Overview:
Reader/consumer side of the bullet table's second (damage/collision) index port. Once per frame it walks the bullets by index, reads position/size/colour/render flag and tests each rendered bullet against the player (soul) box. It then applies damage or healing to the player HP and returns a per-bullet keep-render mask with a one-cycle completion pulse. It sits between the bullet table, the player-movement block and the HUD/game-over logic.

Parameters:
NUM_BULLETS, 3, bullets scanned per frame; legal 1..8; sets width of indexCollide.
HP_INIT, 20, HP after reset; 8-bit value.
DAMAGE, 4, HP removed per damaging hit.
HEAL, 1, HP added per green hit; saturates at HP_INIT.
INVULN_FRAMES, 30, scans of invulnerability after damage (INVULN_EN only).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  frame tick; begins a scan when idle
player_pos  in  16  [15:8]=X, [7:0]=Y of player top-left
player_size  in  16  [15:8]=W, [7:0]=H
player_moving  in  1  player moved this frame
index2  out  3  bullet index driven to bullet table
position2  in  16  bullet [15:8]=X, [7:0]=Y
size2  in  16  bullet [15:8]=W, [7:0]=H
color2  in  2  0=white, 1=green, 2=blue, 3=reserved
isRender2  in  1  bullet currently drawn
indexCollide  out  NUM_BULLETS  keep-render mask; bit i=1 keeps bullet i drawn
isComplete  out  1  one-cycle pulse: mask and hp valid
hp  out  8  current player HP
dead  out  1  hp==0
hit  out  1  one-cycle pulse on any damaging hit in a scan

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, index2=0, indexCollide=all ones, isComplete=0, hit=0, hp=HP_INIT, dead=0. Reset mid-scan aborts the scan; no partial mask is published.
- States: IDLE -> SCAN -> DONE -> IDLE.
- IDLE: start=1 at edge T0 -> SCAN, index2=0. start is ignored in SCAN and DONE (no queuing).
- SCAN: bullet table read is combinational. At edge Tk (k=1..NUM_BULLETS), bullet k-1 is evaluated and index2 advances to k. At T_NUM_BULLETS the state goes to DONE.
- Overlap: 9-bit unsigned arithmetic, strict inequalities: bx < px+pw AND px < bx+bw AND by < py+ph AND py < by+bh. Zero width or height never overlaps.
- Per-bullet result (working mask bit k-1):
  - isRender2=0 -> bit 0, no HP effect.
  - no overlap -> bit 1.
  - white overlap -> damage, bit 0.
  - blue overlap -> damage and bit 0 only if player_moving=1 (sampled at that edge); otherwise bit 1.
  - green overlap -> heal, bit 0.
  - colour 3 -> treated as no overlap.
- HP is updated sequentially per bullet within the scan:
  - damage: hp = max(hp-DAMAGE, 0).
  - heal: hp = min(hp+HEAL, HP_INIT).
  - When hp==0, heals and damage are ignored. dead stays latched until reset.
- DONE: isComplete=1 for exactly one cycle (the cycle after edge T_NUM_BULLETS). indexCollide is updated from the working mask at that same edge and held until the next DONE. hit pulses in the same cycle if any damaging hit occurred. Next edge -> IDLE, index2=0.
- Latency: start accepted at T0 -> isComplete high during cycle T_NUM_BULLETS..T_NUM_BULLETS+1. Minimum start-to-start period is NUM_BULLETS+2 cycles.

Optional Feature:
Macro BULLET_SCAN_INVULN_EN.
- Defined: a damaging hit loads a frame counter with INVULN_FRAMES, decremented at each DONE after the loading scan. While the counter is nonzero, white/blue overlaps cause no damage, no hit pulse, and keep mask bit 1. Green still heals. Adds output port invuln (1 bit, counter!=0, reset 0).
- Undefined: every damaging hit applies; no counter and no invuln port.

Test Plan:
- Reset, no start -> hp=20, indexCollide=3'b111, isComplete=0, dead=0.
- Player (0x20,0x20,16x16); bullet0 white at (0x28,0x28,8x8) rendered; bullets 1,2 far away; start at T0 -> index2 0,1,2 on successive cycles; isComplete only in cycle after T3; indexCollide=3'b110; hp=16; hit=1.
- Bullet0 blue overlapping, player_moving=0 -> mask bit0=1, hp unchanged, hit=0. Repeat with player_moving=1 -> bit0=0, hp-=4.
- Edge touch: bullet X = px+pw exactly -> no overlap, mask bit 1. Green overlap at hp=20 -> hp stays 20, bit 0.
- Repeated white hits from hp=6 -> 2 then 0; dead=1. Further green hit leaves hp=0. start pulsed during SCAN is ignored. Reset asserted at T2 -> IDLE, mask 3'b111, no isComplete.
- With BULLET_SCAN_INVULN_EN, INVULN_FRAMES=2: hit -> invuln=1. The next two scans take no damage; the third scan damages again.
